// File: rtl/a51_pkg.sv
// Shared constants for the A5/1 keystream generator: register geometry, taps and FSM states.
// A51_KEYGEN_FRAME_AUTOINC_EN adds the HOLD state used for frame auto-increment.
package a51_pkg;

  localparam int R1_LEN = 19;
  localparam int R2_LEN = 22;
  localparam int R3_LEN = 23;

  localparam logic [R1_LEN-1:0] R1_TAPS = 19'h72000;    // bits 18,17,16,13
  localparam logic [R2_LEN-1:0] R2_TAPS = 22'h300000;   // bits 21,20
  localparam logic [R3_LEN-1:0] R3_TAPS = 23'h700080;   // bits 22,21,20,7

  localparam int R1_CLK = 8;
  localparam int R2_CLK = 10;
  localparam int R3_CLK = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_KEY,
    S_LOAD_FRAME,
    S_MIX,
    S_STREAM,
    S_DRAIN
`ifdef A51_KEYGEN_FRAME_AUTOINC_EN
    , S_HOLD
`endif
  } state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/a51_lfsr_core.sv
// A5/1 register bank: R1/R2/R3 with majority clocking and a keyed load path.
// ks_bit is the post-step output, so it can be captured on the same edge as the step.
module a51_lfsr_core
  import a51_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic step_all,
  input  logic step_maj,
  input  logic load_bit,
  output logic ks_bit
);

  logic [R1_LEN-1:0] r_r1;
  logic [R2_LEN-1:0] r_r2;
  logic [R3_LEN-1:0] r_r3;

  logic w_maj;
  logic w_en1, w_en2, w_en3;
  logic w_fb1, w_fb2, w_fb3;

  always_comb begin
    w_maj = (r_r1[R1_CLK] & r_r2[R2_CLK]) | (r_r1[R1_CLK] & r_r3[R3_CLK]) |
            (r_r2[R2_CLK] & r_r3[R3_CLK]);
    w_en1 = step_all | (step_maj & (r_r1[R1_CLK] == w_maj));
    w_en2 = step_all | (step_maj & (r_r2[R2_CLK] == w_maj));
    w_en3 = step_all | (step_maj & (r_r3[R3_CLK] == w_maj));
    w_fb1 = (^(r_r1 & R1_TAPS)) ^ load_bit;
    w_fb2 = (^(r_r2 & R2_TAPS)) ^ load_bit;
    w_fb3 = (^(r_r3 & R3_TAPS)) ^ load_bit;
    // A stepping register's next MSB is its current MSB-1
    ks_bit = (w_en1 ? r_r1[R1_LEN-2] : r_r1[R1_LEN-1]) ^
             (w_en2 ? r_r2[R2_LEN-2] : r_r2[R2_LEN-1]) ^
             (w_en3 ? r_r3[R3_LEN-2] : r_r3[R3_LEN-1]);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_r1 <= '0;
      r_r2 <= '0;
      r_r3 <= '0;
    end else begin
      if (w_en1) r_r1 <= {r_r1[R1_LEN-2:0], w_fb1};
      if (w_en2) r_r2 <= {r_r2[R2_LEN-2:0], w_fb2};
      if (w_en3) r_r3 <= {r_r3[R3_LEN-2:0], w_fb3};
    end
  end

endmodule

// File: rtl/a51_stream_keygen.sv
// A5/1 keystream generator: load key/frame, warm up, then stream OUT_W-bit words with backpressure.
// A51_KEYGEN_FRAME_AUTOINC_EN enables HOLD and next_frame restarts with frame+1.
module a51_stream_keygen
  import a51_pkg::*;
#(
  parameter int KEY_W      = 64,
  parameter int FRAME_W    = 22,
  parameter int MIX_CYCLES = 100,
  parameter int KS_LEN     = 228,
  parameter int OUT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [KEY_W-1:0]   key,
  input  logic [FRAME_W-1:0] frame,
  input  logic               next_frame,
  output logic               busy,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               done
);

  localparam int CNT_MAX = max_of(max_of(KEY_W, FRAME_W), max_of(MIX_CYCLES, KS_LEN));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PCNT_W  = $clog2(OUT_W + 1);

  state_t                     r_state, w_state_next;
  logic [CNT_W-1:0]           r_cnt;
  logic [KEY_W+FRAME_W-1:0]   r_ld;
  logic [OUT_W-1:0]           r_pack, r_out_data;
  logic [PCNT_W-1:0]          r_pcnt;
  logic                       r_out_valid, r_out_last, r_busy, r_done;

  logic w_step_all, w_step_maj, w_load_bit, w_clear, w_restart, w_accept;
  logic w_ks_bit, w_can_xfer, w_pack_full, w_xfer, w_stream_go, w_last_acc, w_bit_in;
  logic [KEY_W-1:0]   w_key_src;
  logic [FRAME_W-1:0] w_frame_src;

`ifdef A51_KEYGEN_FRAME_AUTOINC_EN
  logic [KEY_W-1:0]   r_key;
  logic [FRAME_W-1:0] r_frame;

  assign w_key_src   = w_restart ? r_key : key;
  assign w_frame_src = w_restart ? (r_frame + FRAME_W'(1)) : frame;
  assign w_accept    = start & ~r_done & ((r_state == S_IDLE) | (r_state == S_HOLD));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_key   <= '0;
      r_frame <= '0;
    end else if (w_clear) begin
      r_key   <= w_key_src;
      r_frame <= w_frame_src;
    end
  end
`else
  logic w_unused_next_frame;

  assign w_unused_next_frame = next_frame;
  assign w_key_src           = key;
  assign w_frame_src         = frame;
  assign w_accept            = start & ~r_done & (r_state == S_IDLE);
`endif

  assign w_can_xfer  = ~r_out_valid | out_ready;
  assign w_pack_full = (r_pcnt == PCNT_W'(OUT_W));
  // In DRAIN a partially filled packer is flushed as the zero-padded final word
  assign w_xfer      = (w_pack_full | ((r_state == S_DRAIN) & (r_pcnt != '0))) & w_can_xfer;
  assign w_stream_go = (r_state == S_STREAM) & (~w_pack_full | w_can_xfer);
  assign w_last_acc  = r_out_valid & r_out_last & out_ready;
  assign w_bit_in    = w_step_maj & (r_state == S_STREAM);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_step_all   = 1'b0;
    w_step_maj   = 1'b0;
    w_load_bit   = 1'b0;
    w_clear      = 1'b0;
    w_restart    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_clear      = 1'b1;
          w_state_next = S_LOAD_KEY;
        end
      end
      S_LOAD_KEY: begin
        w_step_all = 1'b1;
        w_load_bit = r_ld[0];
        if (r_cnt == CNT_W'(KEY_W - 1)) w_state_next = S_LOAD_FRAME;
      end
      S_LOAD_FRAME: begin
        w_step_all = 1'b1;
        w_load_bit = r_ld[0];
        if (r_cnt == CNT_W'(FRAME_W - 1)) w_state_next = S_MIX;
      end
      S_MIX: begin
        w_step_maj = 1'b1;
        if (r_cnt == CNT_W'(MIX_CYCLES - 1)) w_state_next = S_STREAM;
      end
      S_STREAM: begin
        w_step_maj = w_stream_go;
        if (w_stream_go && (r_cnt == CNT_W'(KS_LEN - 1))) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
`ifdef A51_KEYGEN_FRAME_AUTOINC_EN
        if (w_last_acc) w_state_next = S_HOLD;
`else
        if (w_last_acc) w_state_next = S_IDLE;
`endif
      end
`ifdef A51_KEYGEN_FRAME_AUTOINC_EN
      S_HOLD: begin
        if (w_accept) begin
          w_clear      = 1'b1;
          w_state_next = S_LOAD_KEY;
        end else if (next_frame && !r_done) begin
          w_clear      = 1'b1;
          w_restart    = 1'b1;
          w_state_next = S_LOAD_KEY;
        end
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  a51_lfsr_core u_core (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_clear),
    .step_all (w_step_all),
    .step_maj (w_step_maj),
    .load_bit (w_load_bit),
    .ks_bit   (w_ks_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_ld        <= '0;
      r_pack      <= '0;
      r_pcnt      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_last_acc;
      if (w_clear)         r_busy <= 1'b1;
      else if (w_last_acc) r_busy <= 1'b0;

      if (w_state_next != r_state)     r_cnt <= '0;
      else if (w_step_all | w_step_maj) r_cnt <= r_cnt + CNT_W'(1);

      if (w_clear)         r_ld <= {w_frame_src, w_key_src};
      else if (w_step_all) r_ld <= r_ld >> 1;

      if (w_xfer) begin
        r_out_data  <= r_pack;
        r_out_valid <= 1'b1;
        r_out_last  <= (r_state == S_DRAIN);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end

      // A transfer and a new bit can coincide: the new bit starts the next word
      if (w_clear) begin
        r_pack <= '0;
        r_pcnt <= '0;
      end else if (w_xfer) begin
        r_pack <= w_bit_in ? OUT_W'(w_ks_bit) : '0;
        r_pcnt <= w_bit_in ? PCNT_W'(1) : '0;
      end else if (w_bit_in) begin
        r_pack <= r_pack | (OUT_W'(w_ks_bit) << r_pcnt);
        r_pcnt <= r_pcnt + PCNT_W'(1);
      end
    end
  end

  assign busy      = r_busy;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign done      = r_done;

endmodule

// File: tb/tb_a51_stream_keygen.sv
// Self-checking bench for a51_stream_keygen against a bit-level A5/1 reference model.
// Compiling with A51_KEYGEN_FRAME_AUTOINC_EN adds the frame-wrap continuation run.
module tb_a51_stream_keygen;

  localparam int KEY_W      = 64;
  localparam int FRAME_W    = 22;
  localparam int MIX_CYCLES = 100;
  localparam int KS_LEN     = 228;
  localparam int OUT_W      = 8;
  localparam int FIRST_LAT  = KEY_W + FRAME_W + MIX_CYCLES + OUT_W + 1;
  localparam logic [63:0] KV = 64'h0123456789ABCDEF;
  localparam logic [21:0] FV = 22'h134;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, next_frame = 1'b0, out_ready = 1'b0;
  logic [63:0] key = '0;
  logic [21:0] frame = '0;
  logic        busy, out_valid, out_last, done;
  logic [7:0]  out_data;
  logic        start32 = 1'b0, ready32 = 1'b0, busy32, valid32, last32, done32;
  logic [31:0] data32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  a51_stream_keygen dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .frame(frame),
    .next_frame(next_frame), .busy(busy), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .done(done)
  );

  a51_stream_keygen #(.OUT_W(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .key(key), .frame(frame),
    .next_frame(1'b0), .busy(busy32), .out_data(data32), .out_valid(valid32),
    .out_ready(ready32), .out_last(last32), .done(done32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit parity(input int unsigned v);
    bit p = 1'b0;
    for (int i = 0; i < 32; i++) p ^= bit'(v >> i);
    return p;
  endfunction

  function automatic int unsigned clk_reg(input int unsigned v, input int unsigned len,
                                          input int unsigned taps, input bit lb);
    bit fb = parity(v & taps) ^ lb;
    return ((v << 1) | 32'(fb)) & ((32'd1 << len) - 32'd1);
  endfunction

  // Reference A5/1: registers held as integers, majority taken as a vote count
  function automatic void model_ks(input logic [63:0] k, input logic [21:0] f, output bit ks[$]);
    int unsigned r[3];
    int unsigned len[3];
    int unsigned taps[3];
    int unsigned cb[3];
    len  = '{19, 22, 23};
    taps = '{32'h72000, 32'h300000, 32'h700080};
    cb   = '{8, 10, 10};
    r    = '{0, 0, 0};
    ks   = {};
    for (int i = 0; i < KEY_W + FRAME_W; i++) begin
      bit lb;
      lb = (i < KEY_W) ? bit'(k >> i) : bit'(f >> (i - KEY_W));
      for (int j = 0; j < 3; j++) r[j] = clk_reg(r[j], len[j], taps[j], lb);
    end
    for (int m = 0; m < MIX_CYCLES + KS_LEN; m++) begin
      int votes;
      bit maj;
      bit c[3];
      votes = 0;
      for (int j = 0; j < 3; j++) begin
        c[j] = bit'(r[j] >> cb[j]);
        votes += int'(c[j]);
      end
      maj = (votes >= 2);
      for (int j = 0; j < 3; j++)
        if (c[j] == maj) r[j] = clk_reg(r[j], len[j], taps[j], 1'b0);
      if (m >= MIX_CYCLES) ks.push_back(bit'((r[0] >> 18) ^ (r[1] >> 21) ^ (r[2] >> 22)));
    end
  endfunction

  function automatic void pack_words(input bit ks[$], input int w, output logic [31:0] words[$]);
    logic [31:0] acc = '0;
    words = {};
    for (int i = 0; i < ks.size(); i++) begin
      acc = acc | (32'(ks[i]) << (i % w));
      if (((i % w) == w - 1) || (i == ks.size() - 1)) begin
        words.push_back(acc);
        acc = '0;
      end
    end
  endfunction

  // mode 0: ready high; 1: random ready + 50-cycle hold; 2: start mid-MIX then reset mid-STREAM;
  // 3: launched by next_frame instead of start
  task automatic run_main(input logic [63:0] k, input logic [21:0] f, input int mode, input string tag);
    bit          ks[$];
    logic [31:0] exp_w[$];
    int          cyc, idx, lat, hold_at;
    bit          fin, bad_done, pv, pr, pl;
    logic [7:0]  pd;
    model_ks(k, f, ks);
    pack_words(ks, OUT_W, exp_w);
    repeat (2) @(posedge clk);
    #1;
    key = k; frame = f; out_ready = 1'b1;
    if (mode == 3) next_frame = 1'b1;
    else           start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; next_frame = 1'b0;
    chk({tag, "_busy_rise"}, busy, 1);
    cyc = 0; idx = 0; lat = -1; fin = 0; bad_done = 0;
    hold_at = 200 + $urandom_range(0, 100);
    while (!fin && cyc < 5000) begin
      if (mode == 1)
        out_ready = (cyc >= hold_at && cyc < hold_at + 50) ? 1'b0 : 1'($urandom_range(0, 1));
      else
        out_ready = 1'b1;
      start = (mode == 2 && cyc == 120);
      if (start) begin
        key = ~k; frame = ~f;
      end
      if (mode == 2 && cyc == 229) reset = 1'b1;
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      @(posedge clk); #1;
      cyc++;
      if (reset) begin
        chk({tag, "_reset_outputs"}, {busy, out_valid, out_last, done, out_data}, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_idle_after_reset"}, {busy, out_valid, done}, 0);
        fin = 1;
      end else begin
        if (lat < 0 && out_valid) lat = cyc;
        if (pv && pr) begin
          chk($sformatf("%s_word%0d", tag, idx), pd, exp_w[idx]);
          chk($sformatf("%s_last%0d", tag, idx), pl, (idx == exp_w.size() - 1));
          idx++;
          if (idx == exp_w.size()) begin
            chk({tag, "_done_pulse"}, done, 1);
            chk({tag, "_busy_fall"}, busy, 0);
            fin = 1;
          end
        end else if (pv) begin
          chk($sformatf("%s_hold_c%0d", tag, cyc), {out_valid, out_data}, {1'b1, pd});
        end
        if (!fin && done) bad_done = 1;
      end
    end
    start = 1'b0;
    chk({tag, "_finished"}, fin, 1);
    chk({tag, "_no_stray_done"}, bad_done, 0);
    if (mode == 0) begin
      chk({tag, "_first_valid_latency"}, lat, FIRST_LAT);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_start_on_done_ignored"}, busy, 0);
    end
  endtask

  initial begin
    bit          ks[$];
    logic [31:0] w32[$];
    logic [31:0] pd;
    int          idx, c;
    bit          pv, pl;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_w32", {busy32, valid32, last32, done32, data32}, 0);
    reset = 1'b0;

    run_main(64'h0, 22'h0, 0, "zero");
    run_main(KV, FV, 0, "vec");
    run_main(KV, FV, 1, "bp");
    for (int n = 0; n < 3; n++)
      run_main({$urandom, $urandom}, 22'($urandom), 1, $sformatf("rnd%0d", n));

    model_ks(KV, FV, ks);
    pack_words(ks, 32, w32);
    key = KV; frame = FV; ready32 = 1'b1; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    idx = 0; c = 0;
    while (idx < w32.size() && c < 2000) begin
      pv = valid32; pd = data32; pl = last32;
      @(posedge clk); #1;
      c++;
      if (pv) begin
        chk($sformatf("w32_word%0d", idx), pd, w32[idx]);
        chk($sformatf("w32_last%0d", idx), pl, (idx == w32.size() - 1));
        if (idx == w32.size() - 1) begin
          chk("w32_pad_zero", pd[31:4], 0);
          chk("w32_done", done32, 1);
        end
        idx++;
      end
    end
    chk("w32_word_count", idx, 8);

    run_main(KV, FV, 2, "abort");

`ifdef A51_KEYGEN_FRAME_AUTOINC_EN
    run_main(KV, 22'h3FFFFF, 0, "wrapA");
    run_main(KV, 22'h000000, 3, "wrapB");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
